// File: rtl/tb_mem_arbiter.sv
// rtl/tb_mem_arbiter.sv - round-robin arbiter sharing the single-port testbench memory
// Port 0 is the CPU memory interface, port 1 the debug/loader port; read data returns tagged by owner.
module tb_mem_arbiter #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic                req0_wr,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_wdata,
  input  logic [DATA_W/8-1:0] req0_be,
  input  logic                req0_lock,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic                req1_wr,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_wdata,
  input  logic [DATA_W/8-1:0] req1_be,
  input  logic                req1_lock,
  output logic                rsp0_valid,
  output logic [DATA_W-1:0]   rsp0_rdata,
  output logic                rsp1_valid,
  output logic [DATA_W-1:0]   rsp1_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

`ifdef SIM
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_lat_check
    $error("tb_mem_arbiter: RD_LAT=%0d outside 1..4", RD_LAT);
  end
`endif

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_P0   = 2'd1,
    LOCK_P1   = 2'd2
  } lock_t;

  lock_t             lock_owner, lock_nxt;
  logic              last_grant, last_nxt;
  logic              gnt0, gnt1;
  logic [RD_LAT-1:0] tag_v, tag_p;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_owner <= LOCK_NONE;
      last_grant <= 1'b1;
    end else begin
      lock_owner <= lock_nxt;
      last_grant <= last_nxt;
    end
  end

  // Grant is gated by reset so nothing is accepted while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset) begin
      case (lock_owner)
        LOCK_P0: gnt0 = req0_valid;
        LOCK_P1: gnt1 = req1_valid;
        default: begin
          if (req0_valid && req1_valid) begin
            gnt0 = last_grant;
            gnt1 = !last_grant;
          end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
          end
        end
      endcase
    end
  end

  always_comb begin
    lock_nxt = lock_owner;
    last_nxt = last_grant;
    if (gnt0) begin
      last_nxt = 1'b0;
      lock_nxt = req0_lock ? LOCK_P0 : LOCK_NONE;
    end else if (gnt1) begin
      last_nxt = 1'b1;
      lock_nxt = req1_lock ? LOCK_P1 : LOCK_NONE;
    end
  end

  always_comb begin
    req0_ready = gnt0;
    req1_ready = gnt1;
    mem_en     = gnt0 | gnt1;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_be     = '0;
    if (gnt0) begin
      mem_we    = req0_wr;
      mem_addr  = req0_addr;
      mem_wdata = req0_wdata;
      mem_be    = req0_be;
    end else if (gnt1) begin
      mem_we    = req1_wr;
      mem_addr  = req1_addr;
      mem_wdata = req1_wdata;
      mem_be    = req1_be;
    end
  end

  // Read tags travel alongside the memory latency; stage RD_LAT-1 lines up with mem_rdata.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_v <= '0;
      tag_p <= '0;
    end else begin
      tag_v[0] <= mem_en & !mem_we;
      tag_p[0] <= gnt1;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_p[i] <= tag_p[i-1];
      end
    end
  end

  always_comb begin
    rsp0_valid = tag_v[RD_LAT-1] & !tag_p[RD_LAT-1];
    rsp1_valid = tag_v[RD_LAT-1] &  tag_p[RD_LAT-1];
    rsp0_rdata = rsp0_valid ? mem_rdata : '0;
    rsp1_rdata = rsp1_valid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_tb_mem_arbiter.sv
// tb/tb_tb_mem_arbiter.sv - directed scoreboard bench for tb_mem_arbiter
// Three instances (RD_LAT 1/3/4) share the request stimulus; each has its own memory model.
module tb_tb_mem_arbiter;
  localparam int AW = 20;
  localparam int DW = 64;
  localparam int BW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          r0_valid, r0_wr, r0_lock, r1_valid, r1_wr, r1_lock;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic [BW-1:0] r0_be, r1_be;

  logic [2:0]    ready0, ready1, rsp0_valid, rsp1_valid, mem_en, mem_we;
  logic [DW-1:0] rsp0_rdata [3];
  logic [DW-1:0] rsp1_rdata [3];
  logic [AW-1:0] mem_addr   [3];
  logic [DW-1:0] mem_wdata  [3];
  logic [BW-1:0] mem_be     [3];
  logic [DW-1:0] mem_rdata  [3];

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {12'hC0D, a, 12'h5A5, ~a};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    logic [DW-1:0] mem [256];
    logic [255:0]  wv = '0;
    logic [DW-1:0] dly [L];

    tb_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(L)) u_dut (
      .clk(clk), .reset(reset),
      .req0_valid(r0_valid), .req0_ready(ready0[g]), .req0_wr(r0_wr), .req0_addr(r0_addr),
      .req0_wdata(r0_wdata), .req0_be(r0_be), .req0_lock(r0_lock),
      .req1_valid(r1_valid), .req1_ready(ready1[g]), .req1_wr(r1_wr), .req1_addr(r1_addr),
      .req1_wdata(r1_wdata), .req1_be(r1_be), .req1_lock(r1_lock),
      .rsp0_valid(rsp0_valid[g]), .rsp0_rdata(rsp0_rdata[g]),
      .rsp1_valid(rsp1_valid[g]), .rsp1_rdata(rsp1_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_be(mem_be[g]), .mem_rdata(mem_rdata[g])
    );

    always @(posedge clk) begin : p_mem
      logic [DW-1:0] cur;
      logic [7:0]    a;
      a   = mem_addr[g][7:0];
      cur = wv[a] ? mem[a] : pat(mem_addr[g]);
      if (mem_en[g] && mem_we[g]) begin
        for (int b = 0; b < BW; b++)
          if (mem_be[g][b]) cur[b*8 +: 8] = mem_wdata[g][b*8 +: 8];
        mem[a] <= cur;
        wv[a]  <= 1'b1;
      end
      dly[0] <= (mem_en[g] && !mem_we[g]) ? cur : '0;
      for (int i = 1; i < L; i++) dly[i] <= dly[i-1];
    end
    assign mem_rdata[g] = dly[L-1];
  end

  typedef struct {
    int            due;
    logic          port;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and score any response from the RD_LAT=1 instance.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (rsp0_valid[0] || rsp1_valid[0]) begin
      if (q.size() == 0) begin
        chk("unexpected_rsp", {rsp1_valid[0], rsp0_valid[0]}, 0);
      end else begin
        e = q.pop_front();
        chk("rsp_cycle", cyc, e.due);
        chk("rsp_port", {rsp1_valid[0], rsp0_valid[0]}, e.port ? 2'b10 : 2'b01);
        chk("rsp_data", e.port ? rsp1_rdata[0] : rsp0_rdata[0], e.data);
        chk("rsp_other_rdata", e.port ? rsp0_rdata[0] : rsp1_rdata[0], 0);
      end
    end else if (q.size() > 0 && q[0].due < cyc) begin
      chk("missing_rsp_due", q[0].due, cyc);
      void'(q.pop_front());
    end
  endtask

  task automatic set0(input logic v, input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [BW-1:0] be, input logic lk);
    r0_valid = v; r0_wr = wr; r0_addr = a; r0_wdata = d; r0_be = be; r0_lock = lk;
  endtask

  task automatic set1(input logic v, input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [BW-1:0] be, input logic lk);
    r1_valid = v; r1_wr = wr; r1_addr = a; r1_wdata = d; r1_be = be; r1_lock = lk;
  endtask

  task automatic grant_chk(input string tag, input int g, input logic [AW-1:0] a);
    chk({tag, "_ready0"}, ready0[0], (g == 0));
    chk({tag, "_ready1"}, ready1[0], (g == 1));
    chk({tag, "_mem_en"}, mem_en[0], (g >= 0));
    chk({tag, "_mem_addr"}, mem_addr[0], (g >= 0) ? a : '0);
  endtask

  task automatic push_rd(input logic p, input logic [AW-1:0] a);
    q.push_back('{cyc + 1, p, pat(a)});
  endtask

  initial begin
    logic [DW-1:0] tmp;
    int n0, n1, g;
    reset = 1'b0;
    set0(1'b1, 1'b0, 20'h20, '0, '0, 1'b0);
    set1(1'b1, 1'b0, 20'h40, '0, '0, 1'b0);
    repeat (2) tick();
    #1;
    chk("rst_ready0", ready0, 3'b000);
    chk("rst_ready1", ready1, 3'b000);
    chk("rst_mem_en", mem_en, 3'b000);
    chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 6'b0);

    // Contention: port 0 first after reset, then strict alternation.
    n0 = 0; n1 = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 0) reset = 1'b1;
      set0(1'b1, 1'b0, 20'h20 + AW'(n0), '0, '0, 1'b0);
      set1(1'b1, 1'b0, 20'h40 + AW'(n1), '0, '0, 1'b0);
      #1;
      g = k % 2;
      grant_chk("rr", g, (g == 1) ? 20'h40 + AW'(n1) : 20'h20 + AW'(n0));
      push_rd(g[0], (g == 1) ? 20'h40 + AW'(n1) : 20'h20 + AW'(n0));
      if (g == 1) n1++; else n0++;
    end

    tick();
    set0(1'b0, 1'b0, '0, '0, '0, 1'b0);
    set1(1'b1, 1'b1, 20'h10, 64'hDEADBEEF_00000000, 8'hF0, 1'b0);
    #1;
    grant_chk("wr", 1, 20'h10);
    chk("wr_we", mem_we[0], 1'b1);
    chk("wr_be", mem_be[0], 8'hF0);
    chk("wr_wdata", mem_wdata[0], 64'hDEADBEEF_00000000);
    tick();
    set1(1'b0, 1'b0, '0, '0, '0, 1'b0);
    set0(1'b1, 1'b0, 20'h10, '0, '0, 1'b0);
    #1;
    grant_chk("rd_after_wr", 0, 20'h10);
    chk("rd_after_wr_we", mem_we[0], 1'b0);
    tmp = pat(20'h10);
    q.push_back('{cyc + 1, 1'b0, {32'hDEADBEEF, tmp[31:0]}});

    tick();
    set0(1'b0, 1'b0, '0, '0, '0, 1'b0);
    set1(1'b1, 1'b0, 20'h50, '0, '0, 1'b0);
    #1;
    grant_chk("solo1", 1, 20'h50);
    push_rd(1'b1, 20'h50);

    // Lock: port 1 stays valid and must wait for the unlocked third port-0 access.
    tick();
    set0(1'b1, 1'b0, 20'h60, '0, '0, 1'b1);
    set1(1'b1, 1'b0, 20'h51, '0, '0, 1'b0);
    #1; grant_chk("lock_a", 0, 20'h60); push_rd(1'b0, 20'h60);
    tick();
    set0(1'b1, 1'b0, 20'h61, '0, '0, 1'b1);
    #1; grant_chk("lock_b", 0, 20'h61); push_rd(1'b0, 20'h61);
    tick();
    set0(1'b0, 1'b0, 20'h62, '0, '0, 1'b0);
    #1; grant_chk("lock_hold", -1, '0);
    chk("idle_wdata", mem_wdata[0], '0);
    tick();
    set0(1'b1, 1'b0, 20'h62, '0, '0, 1'b0);
    #1; grant_chk("lock_c", 0, 20'h62); push_rd(1'b0, 20'h62);
    tick();
    set0(1'b1, 1'b0, 20'h63, '0, '0, 1'b0);
    #1; grant_chk("lock_release", 1, 20'h51); push_rd(1'b1, 20'h51);
    tick();
    set1(1'b0, 1'b0, '0, '0, '0, 1'b0);
    #1; grant_chk("after_lock", 0, 20'h63); push_rd(1'b0, 20'h63);
    tick();
    set0(1'b0, 1'b0, '0, '0, '0, 1'b0);
    #1; grant_chk("idle", -1, '0);
    repeat (3) tick();
    chk("queue_drained", q.size(), 0);

    // Latency 3: single port-1 read.
    tick();
    set1(1'b1, 1'b0, 20'h70, '0, '0, 1'b0);
    #1;
    chk("lat3_ready1", ready1[1], 1'b1);
    push_rd(1'b1, 20'h70);
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 1) set1(1'b0, 1'b0, '0, '0, '0, 1'b0);
      #1;
      chk("lat3_rsp1_valid", rsp1_valid[1], (i == 3));
      chk("lat3_rsp0_valid", rsp0_valid[1], 1'b0);
      if (i == 3) chk("lat3_rdata", rsp1_rdata[1], pat(20'h70));
    end

    // Latency 4 read killed by a reset two cycles after issue.
    tick();
    set0(1'b1, 1'b0, 20'h71, '0, '0, 1'b0);
    #1;
    chk("lat4_ready0", ready0[2], 1'b1);
    push_rd(1'b0, 20'h71);
    tick();
    set0(1'b0, 1'b0, '0, '0, '0, 1'b0);
    tick();
    reset = 1'b0;
    set0(1'b1, 1'b0, 20'h72, '0, '0, 1'b0);
    #1;
    chk("midrst_ready0", ready0, 3'b000);
    chk("midrst_mem_en", mem_en, 3'b000);
    tick();
    set0(1'b0, 1'b0, '0, '0, '0, 1'b0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      #1;
      chk("lat4_no_rsp", {rsp1_valid[2], rsp0_valid[2]}, 2'b00);
    end
    chk("queue_end", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
